cssub16_pipe: RTL and testbench

Two-stage pipelined 16-bit carry-select subtractor with valid/ready handshakes on input and output. It computes Diff = A − B − Bin and reports borrow-out plus zero, negative and signed-overflow flags. It sits beside the combinational carry-select adders in the arithmetic datapath and is the subtract path the ALU uses when it needs a registered result with backpressure.

---
 rtl/cssub16_pipe_pkg.sv | 36 +++
 rtl/cssub16_pipe_rcs4.sv | 21 ++
 rtl/cssub16_pipe.sv | 147 ++++++++++++++
 tb/tb_cssub16_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cssub16_pipe_pkg.sv
// cssub16_pipe_pkg
//   Shared arithmetic definitions for the pipelined carry-select subtractor:
//   datapath width, carry-select block size, the stage-1 register layout and
//   the 4-bit 2:1 candidate-select cell.
package cssub16_pipe_pkg;

    localparam int WIDTH      = 16;
    localparam int BLOCK      = 4;
    localparam int NUM_BLOCKS = WIDTH / BLOCK;

    // Everything stage 2 needs to finish the subtraction: the already
    // resolved low byte, the carry into block 2, both candidates of the two
    // upper blocks with their generate/propagate bits, and the operand signs.
    typedef struct packed {
        logic [2*BLOCK-1:0] diff_lo;
        logic               c8;
        logic [BLOCK-1:0]   sum2_c0;
        logic [BLOCK-1:0]   sum2_c1;
        logic [BLOCK-1:0]   sum3_c0;
        logic [BLOCK-1:0]   sum3_c1;
        logic               g2;
        logic               p2;
        logic               g3;
        logic               p3;
        logic               a_msb;
        logic               b_msb;
    } s1_reg_t;

    // 4-bit 2:1 mux cell: picks the carry-in-1 candidate when sel is 1.
    function automatic logic [BLOCK-1:0] mux2_4(input logic             sel,
                                                input logic [BLOCK-1:0] d0,
                                                input logic [BLOCK-1:0] d1);
        return sel ? d1 : d0;
    endfunction

endpackage

// File: rtl/cssub16_pipe_rcs4.sv
// cssub16_pipe_rcs4
//   4-bit ripple adder with inverted B operand: {cout, sum} = a + ~b + cin.
//   Ports:
//     a    in  4  minuend slice
//     b    in  4  subtrahend slice (inverted internally)
//     cin  in  1  carry-in
//     sum  out 4  a + ~b + cin, low 4 bits
//     cout out 1  carry-out
module cssub16_pipe_rcs4
    import cssub16_pipe_pkg::*;
(
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, ~b} + {{BLOCK{1'b0}}, cin};

endmodule

// File: rtl/cssub16_pipe.sv
// cssub16_pipe
//   Two-stage pipelined 16-bit carry-select subtractor, Diff = A - B - Bin,
//   with valid/ready handshakes. Stage 1 resolves the low byte and c8 and
//   keeps both candidates of the upper blocks; stage 2 selects the upper
//   blocks and forms the flags.
//   Ports:
//     clk        in  1   rising-edge clock
//     reset      in  1   synchronous, active-high reset
//     in_valid   in  1   operand set present on A, B, Bin
//     in_ready   out 1   operand set accepted this cycle
//     A, B       in  16  minuend, subtrahend
//     Bin        in  1   borrow-in
//     out_valid  out 1   Diff and flags valid
//     out_ready  in  1   consumer takes the result this cycle
//     Diff       out 16  A - B - Bin mod 2^16
//     Bout       out 1   borrow-out (unsigned A < B + Bin)
//     Zero, Neg, Ovf out 1  result flags
module cssub16_pipe
    import cssub16_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf
);

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ---------------- stage 1: block candidates ----------------
    logic [NUM_BLOCKS-1:0][BLOCK-1:0] sum_c0;
    logic [NUM_BLOCKS-1:0][BLOCK-1:0] sum_c1;
    logic [NUM_BLOCKS-1:0]            g;
    logic [NUM_BLOCKS-1:0]            p;

    for (genvar j = 0; j < NUM_BLOCKS; j++) begin : g_blk
        cssub16_pipe_rcs4 u_cand0 (
            .a    (A[BLOCK*j +: BLOCK]),
            .b    (B[BLOCK*j +: BLOCK]),
            .cin  (1'b0),
            .sum  (sum_c0[j]),
            .cout (g[j])
        );
        cssub16_pipe_rcs4 u_cand1 (
            .a    (A[BLOCK*j +: BLOCK]),
            .b    (B[BLOCK*j +: BLOCK]),
            .cin  (1'b1),
            .sum  (sum_c1[j]),
            .cout (p[j])
        );
    end

    // Subtraction runs as A + ~B + ~Bin, so the chain's carry-in is ~Bin.
    logic    c0;
    logic    c4;
    logic    c8;
    s1_reg_t s1_d;
    s1_reg_t s1_q;

    assign c0 = ~Bin;
    assign c4 = g[0] | (p[0] & c0);
    assign c8 = g[1] | (p[1] & c4);

    always_comb begin
        // NOTE: assign a full default first so no path through the block leaves a field unassigned (which would infer a latch).
        s1_d         = '0;
        s1_d.diff_lo = {mux2_4(c4, sum_c0[1], sum_c1[1]),
                        mux2_4(c0, sum_c0[0], sum_c1[0])};
        s1_d.c8      = c8;
        s1_d.sum2_c0 = sum_c0[2];
        s1_d.sum2_c1 = sum_c1[2];
        s1_d.sum3_c0 = sum_c0[3];
        s1_d.sum3_c1 = sum_c1[3];
        s1_d.g2      = g[2];
        s1_d.p2      = p[2];
        s1_d.g3      = g[3];
        s1_d.p3      = p[3];
        s1_d.a_msb   = A[WIDTH-1];
        s1_d.b_msb   = B[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: the stage-1 payload is not reset; s1_valid qualifies it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_q <= s1_d;
        end
    end

    // ---------------- stage 2: upper-block select and flags ----------------
    logic             c12;
    logic             c16;
    logic [WIDTH-1:0] diff_full;

    assign c12       = s1_q.g2 | (s1_q.p2 & s1_q.c8);
    assign c16       = s1_q.g3 | (s1_q.p3 & c12);
    assign diff_full = {mux2_4(c12,     s1_q.sum3_c0, s1_q.sum3_c1),
                        mux2_4(s1_q.c8, s1_q.sum2_c0, s1_q.sum2_c1),
                        s1_q.diff_lo};

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
            Zero      <= 1'b0;
            Neg       <= 1'b0;
            Ovf       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            // Keep the last result on the outputs while the stage runs empty.
            if (s1_valid) begin
                Diff <= diff_full;
                Bout <= ~c16;
                Zero <= (diff_full == '0);
                Neg  <= diff_full[WIDTH-1];
                Ovf  <= (s1_q.a_msb != s1_q.b_msb) &&
                        (diff_full[WIDTH-1] != s1_q.a_msb);
            end
        end
    end

endmodule

// File: tb/tb_cssub16_pipe.sv
// tb_cssub16_pipe
//   Self-checking bench for cssub16_pipe: directed corner cases, a stalled
//   stream, a mid-flight reset and a randomized run against a reference model
//   built from plain integer arithmetic and an expected-result queue.
module tb_cssub16_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Diff;
    logic        Bout;
    logic        Zero;
    logic        Neg;
    logic        Ovf;

    int          checks   = 0;
    int          failures = 0;
    int          accepted = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    cssub16_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Zero      (Zero),
        .Neg       (Neg),
        .Ovf       (Ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: {Bout, Zero, Neg, Ovf, Diff} from integer arithmetic.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int          ud;
        int          sd;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        ud = int'(a) - int'(b) - int'(bi);
        sd = int'($signed(a)) - int'($signed(b)) - int'(bi);
        d  = ud[15:0];
        bo = (ud < 0);
        ov = (sd > 32767) || (sd < -32768);
        return {bo, (d == 16'h0000), d[15], ov, d};
    endfunction

    // One clock cycle: drive inputs at the falling edge, score transfers
    // just before the rising edge, return 1 time unit after it.
    task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic bi, input logic ordy);
        logic [19:0] e;
        @(negedge clk);
        in_valid  = iv;
        A         = a;
        B         = b;
        Bin       = bi;
        out_ready = ordy;
        #1;
        if (!reset) begin
            if (out_valid && out_ready) begin
                check("queue_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result", {12'h0, Bout, Zero, Neg, Ovf, Diff}, {12'h0, e});
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, bi));
                accepted++;
            end
        end
        @(posedge clk);
        if (reset) exp_q.delete();
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 16'h0, 16'h0, 1'b0, ordy);
    endtask

    function automatic logic [19:0] outs();
        return {Bout, Zero, Neg, Ovf, Diff};
    endfunction

    // Single op with latency check: not visible after the first edge,
    // visible after the second.
    task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input logic [19:0] exp);
        step(1'b1, a, b, bi, 1'b1);
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        idle(1'b1);
        check({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_value"}, {12'h0, outs()}, {12'h0, exp});
        idle(1'b1);
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        idle(1'b0);
        idle(1'b0);
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_outputs",   {12'h0, outs()}, 32'h0);

        // Directed corner cases
        single("sub_0_1",       16'h0000, 16'h0001, 1'b0, {1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF});
        single("sub_8000_1",    16'h8000, 16'h0001, 1'b0, {1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF});
        single("sub_7fff_ffff", 16'h7FFF, 16'hFFFF, 1'b0, {1'b1, 1'b0, 1'b1, 1'b1, 16'h8000});
        single("sub_zero_bin",  16'h1234, 16'h1233, 1'b1, {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});

        // Stalled stream: out_ready low for 4 cycles
        step(1'b1, 16'h0010, 16'h0001, 1'b0, 1'b0);
        check("stall_in_ready_1", 32'(in_ready), 32'd1);
        step(1'b1, 16'h0100, 16'h0010, 1'b0, 1'b0);
        check("stall_in_ready_0", 32'(in_ready), 32'd0);
        check("stall_diff_a",     32'(Diff),     32'h000F);
        step(1'b1, 16'hF000, 16'h0F00, 1'b0, 1'b0);
        check("stall_diff_b",     32'(Diff),     32'h000F);
        step(1'b1, 16'hF000, 16'h0F00, 1'b0, 1'b0);
        check("stall_diff_c",     32'(Diff),     32'h000F);
        check("stall_valid",      32'(out_valid), 32'd1);
        step(1'b1, 16'hF000, 16'h0F00, 1'b0, 1'b1);
        check("drain_valid_2",    32'(out_valid), 32'd1);
        check("drain_diff_2",     32'(Diff),      32'h00F0);
        idle(1'b1);
        check("drain_valid_3",    32'(out_valid), 32'd1);
        check("drain_diff_3",     32'(Diff),      32'hE100);
        idle(1'b1);
        check("drain_empty",      32'(out_valid), 32'd0);
        check("drain_queue",      32'(exp_q.size()), 32'd0);

        // Reset with two results in flight; operands offered during reset
        step(1'b1, 16'h1111, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 16'h0002, 1'b0, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        step(1'b1, 16'h3333, 16'h0001, 1'b0, 1'b0);
        reset = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_outputs",   {12'h0, outs()}, 32'h0);
        single("post_rst", 16'h0005, 16'h0003, 1'b0, {1'b0, 1'b0, 1'b0, 1'b0, 16'h0002});
        idle(1'b1);
        check("post_rst_empty", 32'(out_valid), 32'd0);

        // Randomized run
        accepted = 0;
        begin
            int cyc = 0;
            while (accepted < 10000 && cyc < 40000) begin
                step($urandom_range(0, 3) != 0, rnd16(), rnd16(), 1'($urandom),
                     $urandom_range(0, 3) != 0);
                cyc++;
            end
            check("rand_accepted", 32'(accepted >= 10000), 32'd1);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        idle(1'b1);
        check("rand_final_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
